// File: rtl/registro_palavras_if.sv
// Bus between the word identifier / host side and registro_palavras.
// The identifier drives fim/tipo, the host drives le/limpa and reads the rest.
interface registro_palavras_if #(
    parameter int PROF      = 4,
    parameter int LARG_CONT = 4
);
    localparam int LARG_OCUP = $clog2(PROF) + 1;

    logic                 fim;
    logic [1:0]           tipo;
    logic                 le;
    logic                 limpa;
    logic [1:0]           palavra;
    logic                 valido;
    logic [LARG_OCUP-1:0] ocupacao;
    logic [LARG_CONT-1:0] cont0;
    logic [LARG_CONT-1:0] cont1;
    logic [LARG_CONT-1:0] cont2;
    logic [LARG_CONT-1:0] cont3;
    logic                 estouro;

    modport master (
        output fim, tipo, le, limpa,
        input  palavra, valido, ocupacao, cont0, cont1, cont2, cont3, estouro
    );

    modport slave (
        input  fim, tipo, le, limpa,
        output palavra, valido, ocupacao, cont0, cont1, cont2, cont3, estouro
    );
endinterface

// File: rtl/registro_palavras.sv
// Captures one word type per rising edge of fim into a fall-through FIFO,
// keeps saturating per-type counts and a sticky overflow flag.
module registro_palavras #(
    parameter int PROF      = 4,
    parameter int LARG_CONT = 4
) (
    input  logic               clk,
    input  logic               reset,
    registro_palavras_if.slave bus
);
    localparam int LARG_PTR  = $clog2(PROF);
    localparam int LARG_OCUP = LARG_PTR + 1;
    localparam logic [LARG_OCUP-1:0] OCUP_CHEIA = LARG_OCUP'(PROF);
    localparam logic [LARG_CONT-1:0] CONT_MAX   = '1;

    logic                      fim_r_reg;
    logic [LARG_PTR-1:0]       wr_ptr_reg;
    logic [LARG_PTR-1:0]       rd_ptr_reg;
    logic [LARG_OCUP-1:0]      ocup_reg;
    logic [1:0]                mem_reg [PROF];
    logic                      estouro_reg;
    logic [3:0][LARG_CONT-1:0] cont_val;

    logic captura;
    logic pop;
    logic cheia;
    logic escreve;
    logic descarta;

    // fim_r resets high so a fim already asserted at reset release is ignored.
    assign captura  = bus.fim & ~fim_r_reg;
    assign pop      = bus.le & (ocup_reg != '0);
    assign cheia    = (ocup_reg == OCUP_CHEIA);
    assign escreve  = captura & (~cheia | pop) & ~bus.limpa;
    assign descarta = captura & cheia & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fim_r_reg <= 1'b1;
        end else begin
            fim_r_reg <= bus.fim;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ocup_reg    <= '0;
            estouro_reg <= 1'b0;
        end else if (bus.limpa) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            ocup_reg    <= '0;
            estouro_reg <= 1'b0;
        end else begin
            if (escreve) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({escreve, pop})
                2'b10:   ocup_reg <= ocup_reg + 1'b1;
                2'b01:   ocup_reg <= ocup_reg - 1'b1;
                default: ocup_reg <= ocup_reg;
            endcase
            if (descarta) estouro_reg <= 1'b1;
        end
    end

    // Storage is reset so the fall-through output is never X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PROF; i++) mem_reg[i] <= '0;
        end else if (escreve) begin
            mem_reg[wr_ptr_reg] <= bus.tipo;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cont
            logic [LARG_CONT-1:0] cont_reg;

            // Counts every captured word, including ones dropped by a full FIFO.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cont_reg <= '0;
                end else if (bus.limpa) begin
                    cont_reg <= '0;
                end else if (captura && (bus.tipo == 2'(gi)) && (cont_reg != CONT_MAX)) begin
                    cont_reg <= cont_reg + 1'b1;
                end
            end

            assign cont_val[gi] = cont_reg;
        end
    endgenerate

    assign bus.palavra  = mem_reg[rd_ptr_reg];
    assign bus.valido   = (ocup_reg != '0);
    assign bus.ocupacao = ocup_reg;
    assign bus.cont0    = cont_val[0];
    assign bus.cont1    = cont_val[1];
    assign bus.cont2    = cont_val[2];
    assign bus.cont3    = cont_val[3];
    assign bus.estouro  = estouro_reg;
endmodule

// File: tb/tb_registro_palavras.sv
// Bench for registro_palavras: directed scenarios plus random traffic,
// all checked against a queue-based model of the word register.
module tb_registro_palavras;
    localparam int PROF      = 4;
    localparam int LARG_CONT = 4;
    localparam int LARG_OCUP = $clog2(PROF) + 1;
    localparam int SAT       = (1 << LARG_CONT) - 1;
    localparam int VW        = 1 + LARG_OCUP + 2 + 4 * LARG_CONT + 1;

    logic clk = 1'b0;
    logic reset;

    registro_palavras_if #(.PROF(PROF), .LARG_CONT(LARG_CONT)) bus ();

    registro_palavras #(.PROF(PROF), .LARG_CONT(LARG_CONT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: word queue, per-type counts, sticky overflow, last fim.
    int q[$];
    int cnt[4];
    bit est;
    bit fim_prev;

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0] head;
        head = (q.size() != 0) ? 2'(q[0]) : 2'b0;
        return {q.size() != 0, LARG_OCUP'(q.size()), head,
                LARG_CONT'(cnt[3]), LARG_CONT'(cnt[2]), LARG_CONT'(cnt[1]), LARG_CONT'(cnt[0]), est};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        logic [1:0] head;
        head = (q.size() != 0) ? bus.palavra : 2'b0;
        return {bus.valido, bus.ocupacao, head, bus.cont3, bus.cont2, bus.cont1, bus.cont0, bus.estouro};
    endfunction

    function automatic void model_reset();
        q.delete();
        cnt = '{default: 0};
        est = 1'b0;
        fim_prev = 1'b1;
    endfunction

    // One clock cycle of stimulus; the model advances with the same inputs.
    task automatic step(input bit f, input logic [1:0] t, input bit l, input bit c);
        bit cap;
        bit pop;
        int n;
        bus.fim = f; bus.tipo = t; bus.le = l; bus.limpa = c;
        @(posedge clk);
        cap = f && !fim_prev;
        fim_prev = f;
        pop = 1'b0;
        if (c) begin
            q.delete();
            cnt = '{default: 0};
            est = 1'b0;
        end else begin
            n = q.size();
            pop = l && (n > 0);
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (cnt[t] < SAT) cnt[t]++;
                if (n < PROF || pop) q.push_back(int'(t));
                else est = 1'b1;
            end
        end
        #1;
        if (cap || pop || c)
            $display("t=%0t cap=%0b tipo=%0d pop=%0b limpa=%0b ocupacao=%0d valido=%0b palavra=%0d estouro=%0b",
                     $time, cap, t, pop, c, bus.ocupacao, bus.valido, bus.palavra, bus.estouro);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.fim = 1'b1; bus.tipo = 2'd2; bus.le = 1'b0; bus.limpa = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_vec(), exp_vec());
        end
        checks++;
        if (bus.palavra !== 2'd0) begin
            errors++;
            $display("FAIL reset_palavra got %0d want 0", bus.palavra);
        end
        repeat (3) step(1'b1, 2'd2, 1'b0, 1'b0);
        checks++;
        if ({bus.cont0, bus.cont1, bus.cont2, bus.cont3, bus.valido} !== '0) begin
            errors++;
            $display("FAIL held_fim_no_capture got c2=%0d valido=%0b want 0 0", bus.cont2, bus.valido);
        end
        step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_sequence();
        int tipos[6] = '{1, 1, 2, 2, 3, 3};
        int lidos[4] = '{1, 1, 2, 2};
        step(1'b0, 2'd0, 1'b0, 1'b1);
        foreach (tipos[i]) begin
            step(1'b1, 2'(tipos[i]), 1'b0, 1'b0);
            step(1'b0, 2'(tipos[i]), 1'b0, 1'b0);
        end
        checks++;
        if (bus.ocupacao !== 3'd4 || bus.estouro !== 1'b1) begin
            errors++;
            $display("FAIL seq_full got ocup=%0d estouro=%0b want 4 1", bus.ocupacao, bus.estouro);
        end
        checks++;
        if (bus.cont1 !== 4'd2 || bus.cont2 !== 4'd2 || bus.cont3 !== 4'd2 || bus.cont0 !== 4'd0) begin
            errors++;
            $display("FAIL seq_counts got %0d %0d %0d %0d want 0 2 2 2", bus.cont0, bus.cont1, bus.cont2, bus.cont3);
        end
        foreach (lidos[i]) begin
            checks++;
            if (bus.valido !== 1'b1 || bus.palavra !== 2'(lidos[i])) begin
                errors++;
                $display("FAIL seq_read%0d got v=%0b p=%0d want 1 %0d", i, bus.valido, bus.palavra, lidos[i]);
            end
            step(1'b0, 2'd0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.valido !== 1'b0 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL seq_drained got valido=%0b vec=%h want 0 %h", bus.valido, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_long_fim();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        repeat (4) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        step(1'b0, 2'd1, 1'b0, 1'b0);
        checks++;
        if (bus.cont2 !== 4'd1 || bus.ocupacao !== 3'd1 || bus.palavra !== 2'd2) begin
            errors++;
            $display("FAIL long_fim got c2=%0d ocup=%0d p=%0d want 1 1 2", bus.cont2, bus.ocupacao, bus.palavra);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL long_fim_model got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_swap();
        int ordem[4] = '{2, 3, 0, 1};
        step(1'b0, 2'd0, 1'b0, 1'b1);
        foreach (ordem[i]) begin
            step(1'b1, 2'((i + 1) % 4), 1'b0, 1'b0);
            step(1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(1'b1, 2'd1, 1'b1, 1'b0);
        checks++;
        if (bus.palavra !== 2'd2 || bus.ocupacao !== 3'd4 || bus.estouro !== 1'b0) begin
            errors++;
            $display("FAIL full_swap got p=%0d ocup=%0d est=%0b want 2 4 0", bus.palavra, bus.ocupacao, bus.estouro);
        end
        step(1'b0, 2'd0, 1'b0, 1'b0);
        foreach (ordem[i]) begin
            checks++;
            if (bus.palavra !== 2'(ordem[i]) || bus.valido !== 1'b1) begin
                errors++;
                $display("FAIL swap_drain%0d got p=%0d v=%0b want %0d 1", i, bus.palavra, bus.valido, ordem[i]);
            end
            step(1'b0, 2'd0, 1'b1, 1'b0);
        end
        // Capture into an empty FIFO together with a read: the read is ignored.
        step(1'b1, 2'd3, 1'b1, 1'b0);
        checks++;
        if (bus.valido !== 1'b1 || bus.palavra !== 2'd3 || bus.ocupacao !== 3'd1) begin
            errors++;
            $display("FAIL empty_cap_le got v=%0b p=%0d ocup=%0d want 1 3 1", bus.valido, bus.palavra, bus.ocupacao);
        end
        step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation_limpa();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (17) begin
            step(1'b1, 2'd0, 1'b0, 1'b0);
            step(1'b0, 2'd0, 1'b1, 1'b0);
        end
        checks++;
        if (bus.cont0 !== 4'd15) begin
            errors++;
            $display("FAIL cont0_saturated got %0d want 15", bus.cont0);
        end
        // Overflow the FIFO so limpa has an estouro to clear.
        repeat (5) begin
            step(1'b1, 2'd1, 1'b0, 1'b0);
            step(1'b0, 2'd0, 1'b0, 1'b0);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pre_limpa got %h want %h", dut_vec(), exp_vec());
        end
        step(1'b0, 2'd0, 1'b0, 1'b1);
        checks++;
        if ({bus.cont0, bus.cont1, bus.cont2, bus.cont3, bus.valido, bus.estouro, bus.ocupacao} !== '0) begin
            errors++;
            $display("FAIL limpa_clear got c0=%0d c1=%0d v=%0b est=%0b ocup=%0d want 0",
                     bus.cont0, bus.cont1, bus.valido, bus.estouro, bus.ocupacao);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (5) begin
            step(1'b1, 2'd3, 1'b0, 1'b0);
            step(1'b0, 2'd0, 1'b0, 1'b0);
        end
        step(1'b0, 2'd0, 1'b1, 1'b0);
        checks++;
        if (bus.ocupacao !== 3'd3 || bus.cont3 !== 4'd5) begin
            errors++;
            $display("FAIL pre_reset got ocup=%0d c3=%0d want 3 5", bus.ocupacao, bus.cont3);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.valido, bus.ocupacao, bus.palavra, bus.cont0, bus.cont1, bus.cont2, bus.cont3, bus.estouro} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b ocup=%0d p=%0d c3=%0d want all 0",
                     bus.valido, bus.ocupacao, bus.palavra, bus.cont3);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, 2'd0, 1'b1, 1'b0);
        checks++;
        if (bus.ocupacao !== 3'd0 || bus.valido !== 1'b0) begin
            errors++;
            $display("FAIL le_empty got ocup=%0d v=%0b want 0 0", bus.ocupacao, bus.valido);
        end
    endtask

    task automatic test_random();
        step(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_long_fim();
        test_full_swap();
        test_saturation_limpa();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
